// File: rtl/uart_tx_fifo_if.sv
// User-side bus of the FIFO-buffered UART transmitter: write strobe and data in,
// serial line and FIFO status out.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] data;
  logic                 tx_en;
  logic                 tx;
  logic                 rfn;
  logic                 busy;
  logic [CNT_W-1:0]     count;
  logic                 overrun;

  modport master (
    output data, tx_en,
    input  tx, rfn, busy, count, overrun
  );

  modport slave (
    input  data, tx_en,
    output tx, rfn, busy, count, overrun
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO; configurable data width,
// parity and stop bits, frames sent back to back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CPB        = 1250,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    if (PAR_ODD) begin
      return ~^word;
    end else begin
      return ^word;
    end
  endfunction

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 rfn_q, rfn_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 wr_s;
  logic                 pop_s;
  logic                 bit_end_s;
  logic                 fifo_ne_s;
  logic [DATA_BITS-1:0] head_s;

  assign fifo_ne_s = (count_q != '0);
  assign head_s    = mem_q[rd_ptr_q];
  assign bit_end_s = (baud_q == BAUD_LAST);

  // FIFO bookkeeping; acceptance uses the registered rfn, i.e. the pre-edge occupancy.
  always_comb begin
    wr_s      = bus.tx_en & rfn_q;
    overrun_d = bus.tx_en & ~rfn_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    rfn_d = (count_d != CNT_FULL);
  end

  // Frame sequencer: each state lasts a whole number of CPB-cycle bit periods.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = 4'd0;
        if (fifo_ne_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          par_d   = parity_bit(head_s);
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          baud_d  = '0;
          bit_d   = 4'd0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (!bit_end_s) begin
          baud_d = baud_q + BAUD_W'(1);
        end else if (bit_q != DATA_LAST) begin
          baud_d  = '0;
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else if (PAR_EN) begin
          baud_d  = '0;
          tx_d    = par_q;
          state_d = S_PARITY;
        end else begin
          baud_d  = '0;
          bit_d   = 4'd0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          baud_d  = '0;
          bit_d   = 4'd0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (!bit_end_s) begin
          baud_d = baud_q + BAUD_W'(1);
        end else if (bit_q != STOP_LAST) begin
          baud_d = '0;
          bit_d  = bit_q + 4'd1;
        end else if (fifo_ne_s) begin
          // Chain straight into the next start bit so no idle cycle appears.
          baud_d  = '0;
          bit_d   = 4'd0;
          pop_s   = 1'b1;
          shift_d = head_s;
          par_d   = parity_bit(head_s);
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          baud_d  = '0;
          bit_d   = 4'd0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = 4'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset drives the line high without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= 4'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rfn_q     <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rfn_q     <= rfn_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; emptiness is tracked by count_q, so contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.rfn     = rfn_q;
  assign bus.busy    = busy_q;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 7N2) at CPB=4 checked
// against a frame-level model of the serial line and FIFO occupancy.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] wdata;
  logic [3:0] en;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [8:0] exp_q[$];

  int DB [4] = '{8, 8, 8, 7};
  int PR [4] = '{0, 2, 1, 0};
  int SB [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_m ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_e ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_o ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_s ();

  assign if_m.data = wdata[7:0];
  assign if_e.data = wdata[7:0];
  assign if_o.data = wdata[7:0];
  assign if_s.data = wdata[6:0];
  assign if_m.tx_en = en[0];
  assign if_e.tx_en = en[1];
  assign if_o.tx_en = en[2];
  assign if_s.tx_en = en[3];

  uart_tx_fifo #(.CPB(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  uart_tx_fifo #(.CPB(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_e (.clk(clk), .rst_n(rst_n), .bus(if_e));
  uart_tx_fifo #(.CPB(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_o (.clk(clk), .rst_n(rst_n), .bus(if_o));
  uart_tx_fifo #(.CPB(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

  logic       tx_a [4];
  logic       busy_a [4];
  logic       rfn_a [4];
  logic       ovr_a [4];
  logic [2:0] cnt_a [4];

  assign tx_a[0] = if_m.tx;   assign busy_a[0] = if_m.busy; assign rfn_a[0] = if_m.rfn;
  assign tx_a[1] = if_e.tx;   assign busy_a[1] = if_e.busy; assign rfn_a[1] = if_e.rfn;
  assign tx_a[2] = if_o.tx;   assign busy_a[2] = if_o.busy; assign rfn_a[2] = if_o.rfn;
  assign tx_a[3] = if_s.tx;   assign busy_a[3] = if_s.busy; assign rfn_a[3] = if_s.rfn;
  assign ovr_a[0] = if_m.overrun; assign cnt_a[0] = if_m.count;
  assign ovr_a[1] = if_e.overrun; assign cnt_a[1] = if_e.count;
  assign ovr_a[2] = if_o.overrun; assign cnt_a[2] = if_o.count;
  assign ovr_a[3] = if_s.overrun; assign cnt_a[3] = if_s.count;

  // Frame length in bit periods for instance i.
  function automatic int frame_bits(input int i);
    return 1 + DB[i] + (((PR[i] == 1) || (PR[i] == 2)) ? 1 : 0) + SB[i];
  endfunction

  // Line level for each bit period of a frame; unused upper positions stay 1.
  function automatic logic [15:0] frame_pattern(input int i, input logic [8:0] w);
    logic [15:0] f;
    int          n;
    logic        ones;
    f    = 16'hFFFF;
    f[0] = 1'b0;
    n    = 1;
    ones = 1'b0;
    for (int b = 0; b < DB[i]; b++) begin
      f[n] = w[b];
      ones = ones ^ w[b];
      n++;
    end
    if (PR[i] == 2) f[n] = ones;
    else if (PR[i] == 1) f[n] = ~ones;
    return f;
  endfunction

  // Write one word to every instance in mask and check each line cycle by cycle.
  task automatic run_frames(input logic [3:0] mask, input logic [8:0] w, input string tag);
    logic [15:0] pat [4];
    int          len [4];
    int          maxl;
    maxl = 0;
    for (int i = 0; i < 4; i++) begin
      pat[i] = frame_pattern(i, w);
      len[i] = frame_bits(i) * CPB;
      if (mask[i] && len[i] > maxl) maxl = len[i];
    end
    @(posedge clk); #1;
    wdata = w;
    en    = mask;
    @(posedge clk); #1;
    en = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        total_cnt++;
        if (cnt_a[i] !== 3'd1 || tx_a[i] !== 1'b1 || busy_a[i] !== 1'b0 || ovr_a[i] !== 1'b0)
          $display("FAIL %s_accept inst%0d got count=%0d tx=%b busy=%b ovr=%b want count=1 tx=1 busy=0 ovr=0",
                   tag, i, cnt_a[i], tx_a[i], busy_a[i], ovr_a[i]);
        else pass_cnt++;
      end
    end
    for (int c = 0; c <= maxl; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (mask[i] && c < len[i]) begin
          total_cnt++;
          if (tx_a[i] !== pat[i][c / CPB] || busy_a[i] !== 1'b1)
            $display("FAIL %s_line inst%0d cycle%0d got tx=%b busy=%b want tx=%b busy=1",
                     tag, i, c, tx_a[i], busy_a[i], pat[i][c / CPB]);
          else pass_cnt++;
        end else if (mask[i] && c == len[i]) begin
          total_cnt++;
          if (tx_a[i] !== 1'b1 || busy_a[i] !== 1'b0 || cnt_a[i] !== 3'd0)
            $display("FAIL %s_end inst%0d got tx=%b busy=%b count=%0d want tx=1 busy=0 count=0",
                     tag, i, tx_a[i], busy_a[i], cnt_a[i]);
          else pass_cnt++;
        end
      end
    end
  endtask

  // Watch instance i's line and decode n frames against words queued in exp_q.
  task automatic decode(input int i, input int n, input string tag);
    int          nb;
    int          to;
    logic [15:0] pat;
    logic [8:0]  w;
    nb = frame_bits(i);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      to = 0;
      while (tx_a[i] !== 1'b0 && to < 600) begin
        @(negedge clk);
        to++;
      end
      total_cnt++;
      if (to >= 600) begin
        $display("FAIL %s_start frame%0d got no start bit in 600 cycles want a start bit", tag, k);
        break;
      end else pass_cnt++;
      w   = exp_q.pop_front();
      pat = frame_pattern(i, w);
      for (int b = 1; b < nb; b++) begin
        repeat (CPB) @(negedge clk);
        total_cnt++;
        if (tx_a[i] !== pat[b])
          $display("FAIL %s_bit frame%0d bit%0d got %b want %b (word %h)", tag, k, b, tx_a[i], pat[b], w);
        else pass_cnt++;
      end
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #12;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (tx_a[i] !== 1'b1 || rfn_a[i] !== 1'b1 || busy_a[i] !== 1'b0 || cnt_a[i] !== 3'd0 || ovr_a[i] !== 1'b0)
        $display("FAIL reset inst%0d got tx=%b rfn=%b busy=%b count=%0d ovr=%b want 1 1 0 0 0",
                 i, tx_a[i], rfn_a[i], busy_a[i], cnt_a[i], ovr_a[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_8n1;
    run_frames(4'b0001, 9'h0A5, "8n1_a5");
    run_frames(4'b0001, 9'($urandom_range(0, 255)), "8n1_rand");
  endtask

  task automatic test_parity;
    run_frames(4'b0110, 9'h007, "par_07");
    run_frames(4'b0110, 9'($urandom_range(0, 255)), "par_rand");
  endtask

  task automatic test_7n2;
    int bad;
    run_frames(4'b1000, 9'h07F, "7n2_7f");
    run_frames(4'b1000, 9'($urandom_range(0, 127)), "7n2_rand");
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_a[3] !== 1'b1 || busy_a[3] !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL 7n2_idle got %0d non-idle cycles want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [8:0]  ws [3];
    logic [15:0] pat [3];
    ws[0] = 9'h011; ws[1] = 9'h022; ws[2] = 9'h033;
    for (int k = 0; k < 3; k++) pat[k] = frame_pattern(0, ws[k]);
    @(posedge clk); #1;
    wdata = ws[0];
    en[0] = 1'b1;
    for (int c = -1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (c == -1) wdata = ws[1];
      else if (c == 0) wdata = ws[2];
      else en[0] = 1'b0;
      @(negedge clk);
      if (c <= 1) begin
        total_cnt++;
        if (cnt_a[0] !== ((c == 1) ? 3'd2 : 3'd1))
          $display("FAIL b2b_count step%0d got %0d want %0d", c, cnt_a[0], (c == 1) ? 2 : 1);
        else pass_cnt++;
      end
      if (c >= 0 && c < 120) begin
        total_cnt++;
        if (tx_a[0] !== pat[c / 40][(c % 40) / CPB] || busy_a[0] !== 1'b1)
          $display("FAIL b2b_line cycle%0d got tx=%b busy=%b want tx=%b busy=1",
                   c, tx_a[0], busy_a[0], pat[c / 40][(c % 40) / CPB]);
        else pass_cnt++;
      end else if (c == 120) begin
        total_cnt++;
        if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || cnt_a[0] !== 3'd0)
          $display("FAIL b2b_end got tx=%b busy=%b count=%0d want 1 0 0", tx_a[0], busy_a[0], cnt_a[0]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_overflow;
    logic [8:0] ws [6];
    int         lows;
    for (int k = 0; k < 6; k++) ws[k] = 9'($urandom_range(0, 255));
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(ws[k]);
    fork
      decode(0, 5, "ovf");
      begin
        @(posedge clk); #1;
        wdata = ws[0];
        en[0] = 1'b1;
        @(posedge clk); #1;
        en[0] = 1'b0;
        @(posedge clk); #1;
        wdata = ws[1];
        en[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
          @(posedge clk); #1;
          if (k < 5) wdata = ws[k + 1];
          else en[0] = 1'b0;
          @(negedge clk);
          total_cnt++;
          if (cnt_a[0] !== 3'((k < 4) ? k : 4) || rfn_a[0] !== (k < 4) || ovr_a[0] !== (k == 5))
            $display("FAIL ovf_write%0d got count=%0d rfn=%b ovr=%b want count=%0d rfn=%b ovr=%b",
                     k, cnt_a[0], rfn_a[0], ovr_a[0], (k < 4) ? k : 4, (k < 4), (k == 5));
          else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (ovr_a[0] !== 1'b0 || cnt_a[0] !== 3'd4)
          $display("FAIL ovf_pulse got ovr=%b count=%0d want ovr=0 count=4", ovr_a[0], cnt_a[0]);
        else pass_cnt++;
      end
    join
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) lows++;
    end
    total_cnt++;
    if (lows != 0 || cnt_a[0] !== 3'd0)
      $display("FAIL ovf_extra got %0d active cycles count=%0d want 0 and 0", lows, cnt_a[0]);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [8:0] w;
    int         gap;
    exp_q.delete();
    @(posedge clk); #1;
    fork
      decode(0, 5, "rnd");
      begin
        for (int k = 0; k < 5; k++) begin
          w   = 9'($urandom_range(0, 255));
          gap = $urandom_range(0, 45);
          exp_q.push_back(w);
          repeat (gap) @(posedge clk);
          if (gap != 0) #1;
          wdata = w;
          en[0] = 1'b1;
          @(posedge clk); #1;
          en[0] = 1'b0;
        end
      end
    join
    total_cnt++;
    if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || cnt_a[0] !== 3'd0)
      $display("FAIL rnd_end got tx=%b busy=%b count=%0d want 1 0 0", tx_a[0], busy_a[0], cnt_a[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    logic [8:0] ws [3];
    int         act;
    for (int k = 0; k < 3; k++) ws[k] = 9'($urandom_range(0, 255));
    @(posedge clk); #1;
    wdata = ws[0];
    en[0] = 1'b1;
    @(posedge clk); #1;
    wdata = ws[1];
    @(posedge clk); #1;
    wdata = ws[2];
    @(posedge clk); #1;
    en[0] = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (cnt_a[0] !== 3'd2) $display("FAIL rst_queued got count=%0d want 2", cnt_a[0]);
    else pass_cnt++;
    repeat (15) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (tx_a[0] !== ws[0][3]) $display("FAIL rst_bit3 got tx=%b want %b", tx_a[0], ws[0][3]);
    else pass_cnt++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || cnt_a[0] !== 3'd0 || rfn_a[0] !== 1'b1)
      $display("FAIL rst_async got tx=%b busy=%b count=%0d rfn=%b want 1 0 0 1",
               tx_a[0], busy_a[0], cnt_a[0], rfn_a[0]);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (80) begin
      @(negedge clk);
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || cnt_a[0] !== 3'd0) act++;
    end
    total_cnt++;
    if (act != 0) $display("FAIL rst_quiet got %0d active cycles want 0", act);
    else pass_cnt++;
    run_frames(4'b0001, 9'($urandom_range(0, 255)), "post_rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wdata = 9'h000;
    en    = 4'b0000;
    rst_n = 1'b0;
    test_reset;
    test_single_8n1;
    test_parity;
    test_7n2;
    test_back_to_back;
    test_overflow;
    test_random;
    test_reset_midframe;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, the successor to the fixed 8N1 transmitter used on the iCEstick designs. It converts bytes (or 5–9-bit words) written by user logic into asynchronous serial frames with configurable data width, parity and stop bits. Back-to-back frames go out with no idle gap. It sits between any on-chip data producer and the board's serial TX pin.

## Interface
- CPB, 1250, clock cycles per bit (12 MHz / 9600 baud); legal ≥ 2
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- FIFO_DEPTH, 4, FIFO entries; power of 2, ≥ 2

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- data  in  DATA_BITS  word to transmit
- tx_en  in  1  write strobe; data is accepted on a clk edge where tx_en=1 and rfn=1
- tx  out  1  serial line, idles high
- rfn  out  1  ready for next; equals !full
- busy  out  1  high while a frame is on the line
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overrun  out  1  one-cycle pulse when tx_en=1 while rfn=0

## Operation
- Reset values while rst_n=0 (async assert, sync release): tx=1, rfn=1, busy=0, count=0, overrun=0, FSM=IDLE, FIFO empty, baud and bit counters 0.
- FIFO: circular buffer with read/write pointers and an occupancy counter. A write with rfn=0 is dropped and existing contents are untouched. Simultaneous write and pop leaves count unchanged. Simultaneous write and pop when full: the write is still dropped, because rfn is computed from pre-edge count.
- Frame format, in order: start bit 0; DATA_BITS data bits, LSB first; optional parity bit; STOP_BITS stop bits of 1.
  - Even parity bit = ^word. Odd parity bit = ~^word.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CPB cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If FIFO non-empty, pop the head into the shift register, go to START, drive tx=0, set busy=1.
  - START → DATA after CPB cycles.
  - DATA: shift out one bit per CPB cycles. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY → STOP after CPB cycles.
  - STOP: tx=1 for STOP_BITS × CPB cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Baud counter: width $clog2(CPB). It counts 0..CPB-1 while busy, wraps to 0, and is held at 0 in IDLE.
- tx is a register output and must be glitch-free.
- PARITY values outside 0..2 behave as 0.

## Timing
- tx_en sampled at edge N, with the FIFO empty and the FSM in IDLE:
  - count=1 after edge N.
  - At edge N+1 the word is popped: tx falls, busy rises, count=0.
  - Latency from accepting write to start bit: 1 cycle.
- Each bit holds tx stable for exactly CPB cycles.
- busy falls one cycle after the last stop-bit cycle, and only if the FIFO is empty.
- overrun is asserted in the cycle after the offending edge, for exactly one cycle per dropped write.
- rfn and count update on the same edge as the write or pop that changes them.
- Reset asserted mid-frame: tx=1 immediately without waiting for a clock, the FIFO is flushed, and the partial frame is abandoned. After release, the first frame starts only after a new write.

## Test plan
- CPB=4, 8N1: write 0xA5 while idle → tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; 40 cycles total; busy high exactly 40 cycles; tx falls 1 cycle after the accepting edge.
- CPB=4, 8E1 then 8O1: write 0x07 → parity bit is 1 under even and 0 under odd; frame is 44 cycles.
- CPB=4, 7N2: write 0x7F → tx = 0, then seven 1s, then two stop 1s; 40 cycles; after the frame, tx stays 1 and busy=0.
- Back-to-back, 8N1, CPB=4: write 0x11, 0x22, 0x33 on consecutive cycles → three frames with start bits at t0, t0+40 and t0+80; tx is never high between stop and the next start; count returns to 0.
- FIFO_DEPTH=4: after the first frame starts, write 5 more words → 4 accepted, rfn=0 when count=4, the 5th write raises overrun for 1 cycle, exactly 5 frames are sent with no lost or duplicated data.
- Assert rst_n=0 in the middle of data bit 3 with 2 words queued → tx=1 asynchronously, count=0, busy=0, no further frames; a write after release sends one correct frame.
